sprite_draw_scheduler: RTL and testbench
========================================

// Module: sprite_draw_scheduler
// PURPOSE
//  Shares the single framebuffer write port (x, y, colour, plot) between the player sprite and
//  NUM_ENEMIES enemy sprites. Each sprite raises a one-cycle move request. The block then erases
//  the sprite's previous rectangle in the background colour and draws its new rectangle.
//  It sits between player_control/enemy_control instances and the VGA framebuffer adapter.
//  After reset it clears the whole 160x120 screen before serving any request.
// PARAMETERS
//  NUM_ENEMIES   3       number of enemy sprites; requester 0 = player, 1..NUM_ENEMIES = enemies
//  PLAYER_SIZE   3       player square edge in pixels (1..7)
//  BG_COLOUR     3'b000  erase / clear colour
//  PLAYER_COLOUR 3'b010  player draw colour
//  ENEMY_COLOUR  3'b100  enemy draw colour
// PORTS
//  clk          in   1           clock
//  resetn       in   1           synchronous active-low reset
//  player_move  in   1           one-cycle pulse: player coords changed
//  player_x     in   8           player top-left x
//  player_y     in   7           player top-left y
//  enemy_move   in   NUM_ENEMIES one-cycle pulse per enemy (bit i = enemy i)
//  enemy_x      in   8*NUM_ENEMIES  packed enemy top-left x, enemy i at [8i+7:8i]
//  enemy_y      in   7*NUM_ENEMIES  packed enemy top-left y, enemy i at [7i+6:7i]
//  enemy_size   in   3*NUM_ENEMIES  packed enemy edge length, enemy i at [3i+2:3i]
//  x            out  8           framebuffer write x (registered)
//  y            out  7           framebuffer write y (registered)
//  colour       out  3           framebuffer write colour (registered)
//  plot         out  1           write strobe, one pixel per cycle when high
//  busy         out  1           high in every state except IDLE
// BEHAVIOUR
//  - Reset: plot=0, x=0, y=0, colour=BG_COLOUR, busy=1, all pending bits=0, rr pointer=0.
//    FSM enters CLEAR. A reset during any state aborts it immediately.
//  - CLEAR: sweeps y=0..119 (outer) and x=0..159 (inner) with plot=1 and colour=BG, one pixel per
//    cycle, 19200 plots. On the last pixel, the old-coordinate table is loaded from the current
//    inputs and all NUM_ENEMIES+1 pending bits are set.
//  - Pending: a move pulse sets pending[i] on the next edge. If the pulse arrives in the same
//    cycle that pending[i] is cleared, set wins. Requests arriving in CLEAR are kept.
//  - IDLE: if any pending bit is set, grant by round-robin starting at rr pointer (wrap after
//    NUM_ENEMIES). The granted sprite's current x, y and size (player: PLAYER_SIZE) are
//    snapshotted, its pending bit is cleared, rr pointer = grant+1 (mod N+1), and the FSM goes to
//    ERASE. Input changes during service do not affect the snapshot.
//  - ERASE: iterates dy=0..s-1 (outer), dx=0..s-1 (inner) over old_x/old_y, one cycle per pixel,
//    colour=BG.
//  - DRAW: same iteration over the snapshot coords; colour is PLAYER_COLOUR or ENEMY_COLOUR.
//    On the last pixel, old[grant] = snapshot and the FSM returns to IDLE.
//  - Clipping: coordinate sums are computed 9/8 bits wide. A pixel with x>=160 or y>=120 still
//    takes its cycle but has plot=0.
//  - Size 0: ERASE and DRAW are skipped; old coords are updated; 1-cycle service.
//  - Timing: one service = 1 grant cycle + 2*s*s pixel cycles.
//    First plot=1 appears 2 edges after the move pulse is sampled when idle.
//    Outputs are registered: x/y/colour/plot change only on clk edges.
//  - plot=0 in IDLE and in the grant cycle.
// TESTING
//  1 reset 1 cycle -> exactly 19200 plot cycles with colour 0; first (0,0), last (159,119);
//    then N+1 services of sprites 0,1,2,3 in order.
//  2 player (80,100)->(79,100), one pulse -> 9 BG plots x80..82/y100..102 row-major, then
//    9 PLAYER_COLOUR plots x79..81; busy drops after.
//  3 player_move and enemy_move=3'b101 in same cycle, rr=0 -> service order 0,1,3;
//    then one new pulse on 0 and 1 -> order 1 precedes 0 (rr=... wraps correctly).
//  4 enemy 1 size 3 at x=158 -> per row only x158,159 plotted; third column cycle has plot=0;
//    total cycles still 9 per phase.
//  5 player pulse mid-service of the player -> second service follows, erasing the snapshot
//    coords of the first.
//  6 resetn low during DRAW -> next cycle plot=0; then CLEAR restarts at (0,0); enemy size 0 ->
//    1-cycle service with no plots.

Source files
------------

// File: rtl/sprite_draw_scheduler.sv
// sprite_draw_scheduler: round-robin arbiter sharing one framebuffer write port between sprites,
// clearing the screen after reset, then erasing each moved sprite's old square and drawing the new one.
module sprite_draw_scheduler #(
  parameter int NUM_ENEMIES = 3,
  parameter int PLAYER_SIZE = 3,
  parameter logic [2:0] BG_COLOUR = 3'b000,
  parameter logic [2:0] PLAYER_COLOUR = 3'b010,
  parameter logic [2:0] ENEMY_COLOUR = 3'b100
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     player_move,
  input  logic [7:0]               player_x,
  input  logic [6:0]               player_y,
  input  logic [NUM_ENEMIES-1:0]   enemy_move,
  input  logic [8*NUM_ENEMIES-1:0] enemy_x,
  input  logic [7*NUM_ENEMIES-1:0] enemy_y,
  input  logic [3*NUM_ENEMIES-1:0] enemy_size,
  output logic [7:0]               x,
  output logic [6:0]               y,
  output logic [2:0]               colour,
  output logic                     plot,
  output logic                     busy
);
  localparam int N = NUM_ENEMIES + 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {CLEAR, IDLE, ERASE, DRAW} state_t;
  state_t state, state_nxt;
  logic [N-1:0] pending, req, clr_mask;
  logic [IW-1:0] rr, gnt, cur;
  logic hit, grant, clear_last, col_last, rect_last, in_rect, pix_plot;
  logic [7:0] req_x [N];
  logic [6:0] req_y [N];
  logic [2:0] req_s [N];
  logic [7:0] old_x [N];
  logic [6:0] old_y [N];
  logic [7:0] snap_x, cnt_x;
  logic [6:0] snap_y, cnt_y;
  logic [2:0] snap_s, pcol;
  logic [8:0] px;
  logic [7:0] py;
  assign req = {enemy_move, player_move};
  assign busy = state != IDLE;
  assign grant = state == IDLE && hit;
  assign clear_last = cnt_x == 8'd159 && cnt_y == 7'd119;
  assign col_last = cnt_x[2:0] == snap_s - 3'd1;
  assign rect_last = col_last && cnt_y[2:0] == snap_s - 3'd1;
  assign in_rect = state == ERASE || state == DRAW;
  assign clr_mask = grant ? N'(1) << gnt : '0;
  always_comb begin
    req_x[0] = player_x;
    req_y[0] = player_y;
    req_s[0] = 3'(PLAYER_SIZE);
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      req_x[i+1] = enemy_x[8*i +: 8];
      req_y[i+1] = enemy_y[7*i +: 7];
      req_s[i+1] = enemy_size[3*i +: 3];
    end
  end
  // lowest pending index overall, overridden by the lowest one at or above rr
  always_comb begin
    gnt = '0;
    hit = 1'b0;
    for (int i = N - 1; i >= 0; i--) if (pending[i]) begin gnt = IW'(i); hit = 1'b1; end
    for (int i = N - 1; i >= 0; i--) if (pending[i] && i >= int'(rr)) gnt = IW'(i);
  end
  assign px = in_rect ? {1'b0, (state == ERASE ? old_x[cur] : snap_x)} + {6'd0, cnt_x[2:0]} : {1'b0, cnt_x};
  assign py = in_rect ? {1'b0, (state == ERASE ? old_y[cur] : snap_y)} + {5'd0, cnt_y[2:0]} : {1'b0, cnt_y};
  assign pcol = state == DRAW ? (cur == '0 ? PLAYER_COLOUR : ENEMY_COLOUR) : BG_COLOUR;
  assign pix_plot = state == CLEAR || (in_rect && px < 9'd160 && py < 8'd120);
  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR: if (clear_last) state_nxt = IDLE;
      IDLE:  if (hit && req_s[gnt] != 3'd0) state_nxt = ERASE;
      ERASE: if (rect_last) state_nxt = DRAW;
      DRAW:  if (rect_last) state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) state <= !resetn ? CLEAR : state_nxt;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      plot <= 1'b0;
      x <= '0;
      y <= '0;
      colour <= BG_COLOUR;
      pending <= '0;
      rr <= '0;
      cnt_x <= '0;
      cnt_y <= '0;
    end else begin
      x <= px[7:0];
      y <= py[6:0];
      colour <= pcol;
      plot <= pix_plot;
      pending <= (state == CLEAR && clear_last) ? '1 : (pending & ~clr_mask) | req;
      if (grant) rr <= (gnt == IW'(NUM_ENEMIES)) ? '0 : gnt + 1'b1;
      if (state == CLEAR) begin
        cnt_x <= cnt_x == 8'd159 ? 8'd0 : cnt_x + 8'd1;
        if (cnt_x == 8'd159) cnt_y <= cnt_y == 7'd119 ? 7'd0 : cnt_y + 7'd1;
      end else if (in_rect) begin
        cnt_x <= col_last ? 8'd0 : cnt_x + 8'd1;
        if (col_last) cnt_y <= rect_last ? 7'd0 : cnt_y + 7'd1;
      end else begin
        cnt_x <= '0;
        cnt_y <= '0;
      end
    end
  end
  // snapshot and last-drawn position table need no reset; CLEAR reloads the table
  always_ff @(posedge clk) begin
    if (resetn) begin
      if (grant) begin
        cur <= gnt;
        snap_x <= req_x[gnt];
        snap_y <= req_y[gnt];
        snap_s <= req_s[gnt];
      end
      for (int i = 0; i < N; i++) begin
        if (state == CLEAR && clear_last) begin
          old_x[i] <= req_x[i];
          old_y[i] <= req_y[i];
        end else if (grant && req_s[gnt] == 3'd0 && gnt == IW'(i)) begin
          old_x[i] <= req_x[i];
          old_y[i] <= req_y[i];
        end else if (state == DRAW && rect_last && cur == IW'(i)) begin
          old_x[i] <= snap_x;
          old_y[i] <= snap_y;
        end
      end
    end
  end
endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// tb_sprite_draw_scheduler: directed scenarios for the sprite draw scheduler; plots are logged
// as {x,y,colour} and compared against hand-computed sequences.
module tb_sprite_draw_scheduler;
  logic clk = 1'b0;
  logic resetn, player_move;
  logic [7:0] player_x;
  logic [6:0] player_y;
  logic [2:0] enemy_move;
  logic [23:0] enemy_x;
  logic [20:0] enemy_y;
  logic [8:0] enemy_size;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic plot, busy;
  int errors = 0, checks = 0, busy_cnt = 0;
  logic [17:0] log_q [$];
  bit ok;

  sprite_draw_scheduler dut (
    .clk(clk), .resetn(resetn), .player_move(player_move), .player_x(player_x), .player_y(player_y),
    .enemy_move(enemy_move), .enemy_x(enemy_x), .enemy_y(enemy_y), .enemy_size(enemy_size),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (plot === 1'b1) log_q.push_back({x, y, colour});
    if (busy === 1'b1) busy_cnt++;
  end

  function automatic logic [17:0] pk(input int px, input int py, input int pc);
    return {8'(px), 7'(py), 3'(pc)};
  endfunction

  function automatic logic [17:0] at(input int i);
    return (i < log_q.size()) ? log_q[i] : 18'h3ffff;
  endfunction

  task automatic pulse(input logic p, input logic [2:0] e);
    @(negedge clk);
    player_move = p;
    enemy_move = e;
    @(negedge clk);
    player_move = 1'b0;
    enemy_move = 3'b000;
  endtask

  task automatic wait_idle(input int max, output bit done);
    int run = 0;
    done = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      run = busy ? 0 : run + 1;
      if (run >= 3) begin done = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    int nz = 0;
    resetn = 1'b0;
    @(negedge clk);
    checks++; if (plot !== 1'b0) begin errors++; $display("FAIL reset_plot: got %b want 0", plot); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", busy); end
    checks++; if ({x, y, colour} !== 18'd0) begin errors++; $display("FAIL reset_xyc: got %h want 0", {x, y, colour}); end
    resetn = 1'b1;
    wait_idle(25000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL clear_timeout: got busy want idle"); end
    checks++; if (log_q.size() != 19236) begin errors++; $display("FAIL clear_count: got %0d want 19236", log_q.size()); end
    checks++; if (at(0) !== pk(0, 0, 0)) begin errors++; $display("FAIL clear_first: got %h want %h", at(0), pk(0, 0, 0)); end
    checks++; if (at(19199) !== pk(159, 119, 0)) begin errors++; $display("FAIL clear_last: got %h want %h", at(19199), pk(159, 119, 0)); end
    for (int i = 0; i < 19200 && i < log_q.size(); i++) if (log_q[i][2:0] != 3'd0) nz++;
    checks++; if (nz != 0) begin errors++; $display("FAIL clear_colour: got %0d nonzero want 0", nz); end
    checks++; if (at(19200) !== pk(10, 10, 0)) begin errors++; $display("FAIL init_p_erase: got %h want %h", at(19200), pk(10, 10, 0)); end
    checks++; if (at(19209) !== pk(10, 10, 2)) begin errors++; $display("FAIL init_p_draw: got %h want %h", at(19209), pk(10, 10, 2)); end
    checks++; if (at(19218) !== pk(20, 20, 0)) begin errors++; $display("FAIL init_e0_erase: got %h want %h", at(19218), pk(20, 20, 0)); end
    checks++; if (at(19222) !== pk(20, 20, 4)) begin errors++; $display("FAIL init_e0_draw: got %h want %h", at(19222), pk(20, 20, 4)); end
    checks++; if (at(19226) !== pk(30, 30, 0)) begin errors++; $display("FAIL init_e1_erase: got %h want %h", at(19226), pk(30, 30, 0)); end
    checks++; if (at(19227) !== pk(30, 30, 4)) begin errors++; $display("FAIL init_e1_draw: got %h want %h", at(19227), pk(30, 30, 4)); end
    checks++; if (at(19235) !== pk(41, 41, 4)) begin errors++; $display("FAIL init_e2_last: got %h want %h", at(19235), pk(41, 41, 4)); end
  endtask

  task automatic test_player_move;
    player_x = 8'd80;
    player_y = 7'd100;
    pulse(1'b1, 3'b000);
    wait_idle(200, ok);
    log_q.delete();
    busy_cnt = 0;
    player_x = 8'd79;
    pulse(1'b1, 3'b000);
    @(negedge clk);
    checks++; if ({plot, busy} !== 2'b01) begin errors++; $display("FAIL grant_cycle: got plot,busy=%b want 01", {plot, busy}); end
    @(negedge clk);
    checks++; if ({plot, x, y, colour} !== {1'b1, pk(80, 100, 0)}) begin errors++; $display("FAIL first_plot: got %h want %h", {plot, x, y, colour}, {1'b1, pk(80, 100, 0)}); end
    wait_idle(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL move_timeout: got busy want idle"); end
    checks++; if (log_q.size() != 18) begin errors++; $display("FAIL move_count: got %0d want 18", log_q.size()); end
    checks++; if (busy_cnt != 18) begin errors++; $display("FAIL move_busy: got %0d want 18", busy_cnt); end
    checks++; if (at(2) !== pk(82, 100, 0)) begin errors++; $display("FAIL move_e2: got %h want %h", at(2), pk(82, 100, 0)); end
    checks++; if (at(3) !== pk(80, 101, 0)) begin errors++; $display("FAIL move_e3: got %h want %h", at(3), pk(80, 101, 0)); end
    checks++; if (at(8) !== pk(82, 102, 0)) begin errors++; $display("FAIL move_e8: got %h want %h", at(8), pk(82, 102, 0)); end
    checks++; if (at(9) !== pk(79, 100, 2)) begin errors++; $display("FAIL move_d0: got %h want %h", at(9), pk(79, 100, 2)); end
    checks++; if (at(17) !== pk(81, 102, 2)) begin errors++; $display("FAIL move_d8: got %h want %h", at(17), pk(81, 102, 2)); end
  endtask

  task automatic test_round_robin;
    enemy_x[23:16] = 8'd70;
    enemy_y[20:14] = 7'd70;
    pulse(1'b0, 3'b100);
    wait_idle(200, ok);
    player_x = 8'd50;
    player_y = 7'd50;
    enemy_x[7:0] = 8'd60;
    enemy_y[6:0] = 7'd60;
    log_q.delete();
    pulse(1'b1, 3'b101);
    wait_idle(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rr_a_timeout: got busy want idle"); end
    checks++; if (log_q.size() != 34) begin errors++; $display("FAIL rr_a_count: got %0d want 34", log_q.size()); end
    checks++; if (at(0) !== pk(79, 100, 0)) begin errors++; $display("FAIL rr_a_p_erase: got %h want %h", at(0), pk(79, 100, 0)); end
    checks++; if (at(9) !== pk(50, 50, 2)) begin errors++; $display("FAIL rr_a_p_draw: got %h want %h", at(9), pk(50, 50, 2)); end
    checks++; if (at(18) !== pk(20, 20, 0)) begin errors++; $display("FAIL rr_a_e0_erase: got %h want %h", at(18), pk(20, 20, 0)); end
    checks++; if (at(22) !== pk(60, 60, 4)) begin errors++; $display("FAIL rr_a_e0_draw: got %h want %h", at(22), pk(60, 60, 4)); end
    checks++; if (at(26) !== pk(70, 70, 0)) begin errors++; $display("FAIL rr_a_e2_erase: got %h want %h", at(26), pk(70, 70, 0)); end
    checks++; if (at(30) !== pk(70, 70, 4)) begin errors++; $display("FAIL rr_a_e2_draw: got %h want %h", at(30), pk(70, 70, 4)); end
    player_x = 8'd52;
    enemy_x[7:0] = 8'd62;
    log_q.delete();
    pulse(1'b1, 3'b000);
    repeat (2) @(negedge clk);
    pulse(1'b1, 3'b001);
    wait_idle(300, ok);
    checks++; if (log_q.size() != 44) begin errors++; $display("FAIL rr_b_count: got %0d want 44", log_q.size()); end
    checks++; if (at(9) !== pk(52, 50, 2)) begin errors++; $display("FAIL rr_b_p_draw: got %h want %h", at(9), pk(52, 50, 2)); end
    checks++; if (at(22) !== pk(62, 60, 4)) begin errors++; $display("FAIL rr_b_e0_first: got %h want %h", at(22), pk(62, 60, 4)); end
    checks++; if (at(26) !== pk(52, 50, 0)) begin errors++; $display("FAIL rr_b_p_second: got %h want %h", at(26), pk(52, 50, 0)); end
    checks++; if (at(35) !== pk(52, 50, 2)) begin errors++; $display("FAIL rr_b_p_redraw: got %h want %h", at(35), pk(52, 50, 2)); end
  endtask

  task automatic test_clipping;
    enemy_size[5:3] = 3'd3;
    enemy_x[15:8] = 8'd158;
    enemy_y[13:7] = 7'd10;
    log_q.delete();
    busy_cnt = 0;
    pulse(1'b0, 3'b010);
    wait_idle(200, ok);
    checks++; if (log_q.size() != 15) begin errors++; $display("FAIL clip_count: got %0d want 15", log_q.size()); end
    checks++; if (busy_cnt != 18) begin errors++; $display("FAIL clip_cycles: got %0d want 18", busy_cnt); end
    checks++; if (at(0) !== pk(30, 30, 0)) begin errors++; $display("FAIL clip_erase: got %h want %h", at(0), pk(30, 30, 0)); end
    checks++; if (at(10) !== pk(159, 10, 4)) begin errors++; $display("FAIL clip_row0: got %h want %h", at(10), pk(159, 10, 4)); end
    checks++; if (at(11) !== pk(158, 11, 4)) begin errors++; $display("FAIL clip_row1: got %h want %h", at(11), pk(158, 11, 4)); end
    checks++; if (at(14) !== pk(159, 12, 4)) begin errors++; $display("FAIL clip_last: got %h want %h", at(14), pk(159, 12, 4)); end
  endtask

  task automatic test_mid_service;
    player_x = 8'd20;
    player_y = 7'd30;
    log_q.delete();
    pulse(1'b1, 3'b000);
    repeat (5) @(negedge clk);
    player_x = 8'd25;
    player_y = 7'd35;
    pulse(1'b1, 3'b000);
    wait_idle(300, ok);
    checks++; if (log_q.size() != 36) begin errors++; $display("FAIL mid_count: got %0d want 36", log_q.size()); end
    checks++; if (at(0) !== pk(52, 50, 0)) begin errors++; $display("FAIL mid_erase1: got %h want %h", at(0), pk(52, 50, 0)); end
    checks++; if (at(9) !== pk(20, 30, 2)) begin errors++; $display("FAIL mid_snapshot: got %h want %h", at(9), pk(20, 30, 2)); end
    checks++; if (at(18) !== pk(20, 30, 0)) begin errors++; $display("FAIL mid_erase2: got %h want %h", at(18), pk(20, 30, 0)); end
    checks++; if (at(35) !== pk(27, 37, 2)) begin errors++; $display("FAIL mid_draw2: got %h want %h", at(35), pk(27, 37, 2)); end
  endtask

  task automatic test_reset_abort;
    pulse(1'b1, 3'b000);
    repeat (12) @(negedge clk);
    checks++; if ({plot, colour} !== 4'b1010) begin errors++; $display("FAIL abort_in_draw: got %b want 1010", {plot, colour}); end
    resetn = 1'b0;
    enemy_size[5:3] = 3'd0;
    @(negedge clk);
    checks++; if ({plot, busy, x, y} !== {2'b01, 15'd0}) begin errors++; $display("FAIL abort_reset: got %h want %h", {plot, busy, x, y}, {2'b01, 15'd0}); end
    resetn = 1'b1;
    log_q.delete();
    wait_idle(25000, ok);
    checks++; if (log_q.size() != 19234) begin errors++; $display("FAIL reclear_count: got %0d want 19234", log_q.size()); end
    checks++; if (at(0) !== pk(0, 0, 0)) begin errors++; $display("FAIL reclear_first: got %h want %h", at(0), pk(0, 0, 0)); end
    checks++; if (at(19200) !== pk(25, 35, 0)) begin errors++; $display("FAIL reclear_p: got %h want %h", at(19200), pk(25, 35, 0)); end
    checks++; if (at(19226) !== pk(70, 70, 0)) begin errors++; $display("FAIL reclear_e2: got %h want %h", at(19226), pk(70, 70, 0)); end
    enemy_x[15:8] = 8'd100;
    enemy_y[13:7] = 7'd100;
    log_q.delete();
    busy_cnt = 0;
    pulse(1'b0, 3'b010);
    wait_idle(50, ok);
    checks++; if (log_q.size() != 0 || busy_cnt != 0) begin errors++; $display("FAIL size0: got plots=%0d busy=%0d want 0 0", log_q.size(), busy_cnt); end
    enemy_size[5:3] = 3'd2;
    enemy_x[15:8] = 8'd104;
    log_q.delete();
    pulse(1'b0, 3'b010);
    wait_idle(200, ok);
    checks++; if (log_q.size() != 8) begin errors++; $display("FAIL size0_next_count: got %0d want 8", log_q.size()); end
    checks++; if (at(0) !== pk(100, 100, 0)) begin errors++; $display("FAIL size0_old: got %h want %h", at(0), pk(100, 100, 0)); end
    checks++; if (at(4) !== pk(104, 100, 4)) begin errors++; $display("FAIL size0_draw: got %h want %h", at(4), pk(104, 100, 4)); end
  endtask

  initial begin
    player_move = 1'b0;
    enemy_move = 3'b000;
    player_x = 8'd10;
    player_y = 7'd10;
    enemy_x = {8'd40, 8'd30, 8'd20};
    enemy_y = {7'd40, 7'd30, 7'd20};
    enemy_size = {3'd2, 3'd1, 3'd2};
    test_reset;
    test_player_move;
    test_round_robin;
    test_clipping;
    test_mid_service;
    test_reset_abort;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
